// File: rtl/pe_mem_stream_dispatcher.sv
// rtl/pe_mem_stream_dispatcher.sv - round-robin PE namespace write and weight read-back sequencer
module pe_mem_stream_dispatcher #(
  parameter int dataLen           = 16,
  parameter int logNumPeMemColumn = 2,
  parameter int logMemNamespaces  = 2,
  parameter int countLen          = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_start,
  input  logic                         cfg_dir,
  input  logic [logMemNamespaces-1:0]  cfg_type,
  input  logic [countLen-1:0]          cfg_count,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [dataLen-1:0]           in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [dataLen-1:0]           out_data,
  output logic                         mem_wrt_valid,
  output logic                         mem_weight_rd_valid,
  output logic [logNumPeMemColumn-1:0] peId_mem_in,
  output logic [logMemNamespaces-1:0]  mem_data_type,
  output logic [dataLen-1:0]           mem_data_input,
  input  logic [dataLen-1:0]           mem_data_output,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_DONE
  } state_t;

  localparam logic [logNumPeMemColumn-1:0] col_last  = '1;
  localparam logic [logMemNamespaces-1:0]  weight_ns = logMemNamespaces'(2);

  state_t                         state, state_nxt;
  logic [logMemNamespaces-1:0]    type_q;
  logic [countLen-1:0]            count_q;
  logic [logNumPeMemColumn-1:0]   col, col_nxt;
  logic [countLen-1:0]            word, word_nxt;
  logic                           accept, out_fire, step, last_word;

  assign in_ready  = (state == S_WRITE);
  assign out_valid = (state == S_RD_OUT);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // count_q is never zero outside IDLE/DONE, so count_q-1 cannot underflow where this is used
  assign last_word = (col == col_last) && (word == count_q - countLen'(1));

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    word_nxt  = word;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          col_nxt  = '0;
          word_nxt = '0;
          if (cfg_count == '0) state_nxt = S_DONE;
          else if (cfg_dir)    state_nxt = S_RD_REQ;
          else                 state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          step = 1'b1;
          if (last_word) state_nxt = S_DONE;
        end
      end
      S_RD_REQ:  state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_RD_OUT;
      S_RD_OUT: begin
        if (out_fire) begin
          step      = 1'b1;
          state_nxt = last_word ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (step) begin
      col_nxt = col + logNumPeMemColumn'(1);
      if (col == col_last) word_nxt = word + countLen'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      type_q              <= '0;
      count_q             <= '0;
      col                 <= '0;
      word                <= '0;
      mem_wrt_valid       <= 1'b0;
      mem_weight_rd_valid <= 1'b0;
      peId_mem_in         <= '0;
      mem_data_type       <= '0;
      mem_data_input      <= '0;
      out_data            <= '0;
      done                <= 1'b0;
    end else begin
      state               <= state_nxt;
      col                 <= col_nxt;
      word                <= word_nxt;
      done                <= (state == S_DONE);
      mem_wrt_valid       <= accept;
      // the read strobe is registered on entry so it lines up with the PE id of the word being fetched
      mem_weight_rd_valid <= (state_nxt == S_RD_REQ);
      if (state == S_IDLE && cfg_start) begin
        type_q  <= cfg_type;
        count_q <= cfg_count;
      end
      if (accept) begin
        peId_mem_in    <= col;
        mem_data_type  <= type_q;
        mem_data_input <= in_data;
      end else if (state_nxt == S_RD_REQ) begin
        peId_mem_in   <= col_nxt;
        mem_data_type <= weight_ns;
      end
      if (state == S_RD_WAIT) out_data <= mem_data_output;
    end
  end

endmodule
